// File: rtl/deconvolve_multi.sv
// Multi-channel FADC deconvolver: y = FN*(x - FD*x[n-1]) per channel on one
// time-multiplexed 4-stage pipeline, with frame-atomic coefficient updates.
module deconvolve_multi #(
    parameter int unsigned NCH          = 3,
    parameter int unsigned ADC_WIDTH    = 12,
    parameter int unsigned FD_BITS      = 6,
    parameter int unsigned FN_BITS      = 6,
    parameter int unsigned FN_FRAC_BITS = 4
) (
    input  logic                     CLK,
    input  logic                     RSTN,
    input  logic                     IN_VALID,
    input  logic [NCH*ADC_WIDTH-1:0] ADC_IN,
    input  logic                     BYPASS,
    input  logic                     COEF_LOAD,
    input  logic [NCH*FD_BITS-1:0]   FD_IN,
    input  logic [NCH*FN_BITS-1:0]   FN_IN,
    input  logic                     OVR_CLR,
    output logic                     READY,
    output logic [NCH*ADC_WIDTH-1:0] ADC_OUT,
    output logic                     OUT_VALID,
    output logic                     OVERRUN
);
    localparam int unsigned KW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned AW = ADC_WIDTH + FD_BITS;
    localparam int unsigned BW = AW + 1;
    localparam int unsigned DW = AW + FN_BITS;
    localparam int unsigned EW = DW + 1;
    localparam int unsigned SH = FD_BITS + FN_FRAC_BITS;
    localparam int unsigned YW = EW - SH;

    localparam logic [KW-1:0]      LAST     = KW'(NCH - 1);
    localparam logic [EW-1:0]      RND      = EW'(1) << (SH - 1);
    localparam logic [YW-1:0]      YMAX     = YW'({ADC_WIDTH{1'b1}});
    localparam logic [FN_BITS-1:0] FN_UNITY = FN_BITS'(1) << FN_FRAC_BITS;

    typedef enum logic [0:0] {ST_IDLE, ST_ISSUE} state_t;

    state_t                 state_q, state_d;
    logic [KW-1:0]          k_q, k_d;
    logic                   ready_q, ready_d;
    logic [ADC_WIDTH-1:0]   frame_q [NCH];
    logic [ADC_WIDTH-1:0]   frame_d [NCH];
    logic                   fbyp_q, fbyp_d;
    logic [ADC_WIDTH-1:0]   prev_q [NCH];
    logic [ADC_WIDTH-1:0]   prev_d [NCH];
    logic [FD_BITS-1:0]     fd_act_q [NCH];
    logic [FD_BITS-1:0]     fd_act_d [NCH];
    logic [FN_BITS-1:0]     fn_act_q [NCH];
    logic [FN_BITS-1:0]     fn_act_d [NCH];
    logic [FD_BITS-1:0]     fd_shd_q [NCH];
    logic [FD_BITS-1:0]     fd_shd_d [NCH];
    logic [FN_BITS-1:0]     fn_shd_q [NCH];
    logic [FN_BITS-1:0]     fn_shd_d [NCH];
    logic                   pending_q, pending_d;
    logic                   ovr_q, ovr_d;

    logic                   s1_vld_q, s1_vld_d, s1_byp_q, s1_byp_d;
    logic [KW-1:0]          s1_ch_q, s1_ch_d;
    logic [ADC_WIDTH-1:0]   s1_x_q, s1_x_d;
    logic [AW-1:0]          s1_a_q, s1_a_d, s1_xs_q, s1_xs_d;
    logic [FN_BITS-1:0]     s1_fn_q, s1_fn_d;

    logic                   s2_vld_q, s2_vld_d, s2_byp_q, s2_byp_d;
    logic [KW-1:0]          s2_ch_q, s2_ch_d;
    logic [ADC_WIDTH-1:0]   s2_x_q, s2_x_d;
    logic [AW-1:0]          s2_c_q, s2_c_d;
    logic [FN_BITS-1:0]     s2_fn_q, s2_fn_d;

    logic                   s3_vld_q, s3_vld_d, s3_byp_q, s3_byp_d;
    logic [KW-1:0]          s3_ch_q, s3_ch_d;
    logic [ADC_WIDTH-1:0]   s3_x_q, s3_x_d;
    logic [DW-1:0]          s3_d_q, s3_d_d;

    logic [NCH*ADC_WIDTH-1:0] stage_q, stage_d;
    logic [NCH*ADC_WIDTH-1:0] adc_out_q, adc_out_d;
    logic                     out_vld_q, out_vld_d;

    logic                   issue, accept;
    logic [ADC_WIDTH-1:0]   x_cur;
    logic [BW-1:0]          b_diff;
    logic [EW-1:0]          e_sum;
    logic [YW-1:0]          y_full;
    logic [ADC_WIDTH-1:0]   y_out;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        frame_d   = frame_q;
        fbyp_d    = fbyp_q;
        prev_d    = prev_q;
        fd_act_d  = fd_act_q;
        fn_act_d  = fn_act_q;
        fd_shd_d  = fd_shd_q;
        fn_shd_d  = fn_shd_q;
        pending_d = pending_q;
        ovr_d     = ovr_q;
        stage_d   = stage_q;
        adc_out_d = adc_out_q;
        out_vld_d = 1'b0;

        issue  = (state_q == ST_ISSUE);
        accept = IN_VALID && ((state_q == ST_IDLE) || (k_q == LAST));

        // Sequencer: a new frame may start on the edge the last channel issues
        if (issue) begin
            if (k_q == LAST) begin
                k_d     = '0;
                state_d = accept ? ST_ISSUE : ST_IDLE;
            end else begin
                k_d = k_q + KW'(1);
            end
        end else if (accept) begin
            state_d = ST_ISSUE;
            k_d     = '0;
        end
        ready_d = (state_d == ST_IDLE) || (k_d == LAST);

        if (accept) begin
            for (int c = 0; c < NCH; c++) begin
                frame_d[c] = ADC_IN[c*ADC_WIDTH +: ADC_WIDTH];
            end
            fbyp_d = BYPASS;
        end

        if (IN_VALID && !accept) begin
            ovr_d = 1'b1;
        end else if (OVR_CLR) begin
            ovr_d = 1'b0;
        end

        // Shadow promotes on frame accept; a same-edge load waits for the next frame
        if (accept && pending_q) begin
            fd_act_d  = fd_shd_q;
            fn_act_d  = fn_shd_q;
            pending_d = 1'b0;
        end
        if (COEF_LOAD) begin
            for (int c = 0; c < NCH; c++) begin
                fd_shd_d[c] = FD_IN[c*FD_BITS +: FD_BITS];
                fn_shd_d[c] = FN_IN[c*FN_BITS +: FN_BITS];
            end
            pending_d = 1'b1;
        end

        // S1: history product and aligned new sample
        x_cur    = frame_q[k_q];
        s1_vld_d = issue;
        s1_ch_d  = k_q;
        s1_byp_d = fbyp_q;
        s1_x_d   = x_cur;
        s1_a_d   = AW'(prev_q[k_q]) * AW'(fd_act_q[k_q]);
        s1_xs_d  = {x_cur, FD_BITS'(0)};
        s1_fn_d  = fn_act_q[k_q];
        if (issue) begin
            prev_d[k_q] = x_cur;
        end

        // S2: difference clamped at zero
        b_diff   = {1'b0, s1_xs_q} - {1'b0, s1_a_q};
        s2_vld_d = s1_vld_q;
        s2_ch_d  = s1_ch_q;
        s2_byp_d = s1_byp_q;
        s2_x_d   = s1_x_q;
        s2_c_d   = b_diff[BW-1] ? '0 : b_diff[AW-1:0];
        s2_fn_d  = s1_fn_q;

        // S3: normalise
        s3_vld_d = s2_vld_q;
        s3_ch_d  = s2_ch_q;
        s3_byp_d = s2_byp_q;
        s3_x_d   = s2_x_q;
        s3_d_d   = DW'(s2_c_q) * DW'(s2_fn_q);

        // S4: round, saturate, assemble the frame
        e_sum  = EW'(s3_d_q) + RND;
        y_full = YW'(e_sum >> SH);
        if (s3_byp_q) begin
            y_out = s3_x_q;
        end else if (y_full > YMAX) begin
            y_out = '1;
        end else begin
            y_out = y_full[ADC_WIDTH-1:0];
        end
        if (s3_vld_q) begin
            for (int c = 0; c < NCH; c++) begin
                if (s3_ch_q == KW'(c)) begin
                    stage_d[c*ADC_WIDTH +: ADC_WIDTH] = y_out;
                end
            end
            if (s3_ch_q == LAST) begin
                adc_out_d = stage_q;
                adc_out_d[(NCH-1)*ADC_WIDTH +: ADC_WIDTH] = y_out;
                out_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            ready_q   <= 1'b1;
            frame_q   <= '{default: '0};
            fbyp_q    <= 1'b0;
            prev_q    <= '{default: '0};
            fd_act_q  <= '{default: '0};
            fn_act_q  <= '{default: FN_UNITY};
            fd_shd_q  <= '{default: '0};
            fn_shd_q  <= '{default: FN_UNITY};
            pending_q <= 1'b0;
            ovr_q     <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_ch_q   <= '0;
            s1_byp_q  <= 1'b0;
            s1_x_q    <= '0;
            s1_a_q    <= '0;
            s1_xs_q   <= '0;
            s1_fn_q   <= '0;
            s2_vld_q  <= 1'b0;
            s2_ch_q   <= '0;
            s2_byp_q  <= 1'b0;
            s2_x_q    <= '0;
            s2_c_q    <= '0;
            s2_fn_q   <= '0;
            s3_vld_q  <= 1'b0;
            s3_ch_q   <= '0;
            s3_byp_q  <= 1'b0;
            s3_x_q    <= '0;
            s3_d_q    <= '0;
            stage_q   <= '0;
            adc_out_q <= '0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            ready_q   <= ready_d;
            frame_q   <= frame_d;
            fbyp_q    <= fbyp_d;
            prev_q    <= prev_d;
            fd_act_q  <= fd_act_d;
            fn_act_q  <= fn_act_d;
            fd_shd_q  <= fd_shd_d;
            fn_shd_q  <= fn_shd_d;
            pending_q <= pending_d;
            ovr_q     <= ovr_d;
            s1_vld_q  <= s1_vld_d;
            s1_ch_q   <= s1_ch_d;
            s1_byp_q  <= s1_byp_d;
            s1_x_q    <= s1_x_d;
            s1_a_q    <= s1_a_d;
            s1_xs_q   <= s1_xs_d;
            s1_fn_q   <= s1_fn_d;
            s2_vld_q  <= s2_vld_d;
            s2_ch_q   <= s2_ch_d;
            s2_byp_q  <= s2_byp_d;
            s2_x_q    <= s2_x_d;
            s2_c_q    <= s2_c_d;
            s2_fn_q   <= s2_fn_d;
            s3_vld_q  <= s3_vld_d;
            s3_ch_q   <= s3_ch_d;
            s3_byp_q  <= s3_byp_d;
            s3_x_q    <= s3_x_d;
            s3_d_q    <= s3_d_d;
            stage_q   <= stage_d;
            adc_out_q <= adc_out_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign READY     = ready_q;
    assign ADC_OUT   = adc_out_q;
    assign OUT_VALID = out_vld_q;
    assign OVERRUN   = ovr_q;
endmodule

// File: tb/tb_deconvolve_multi.sv
// Bench for deconvolve_multi: per-cycle comparison against a frame-level model,
// plus directed scenarios with hand-computed literal results.
module tb_deconvolve_multi;
    localparam int unsigned NCH  = 3;
    localparam int unsigned AWID = 12;
    localparam int unsigned FDB  = 6;
    localparam int unsigned FNB  = 6;
    localparam int unsigned FNF  = 4;
    localparam int          LAT  = NCH + 3;

    logic                  CLK = 1'b0;
    logic                  RSTN;
    logic                  IN_VALID;
    logic [NCH*AWID-1:0]   ADC_IN;
    logic                  BYPASS;
    logic                  COEF_LOAD;
    logic [NCH*FDB-1:0]    FD_IN;
    logic [NCH*FNB-1:0]    FN_IN;
    logic                  OVR_CLR;
    logic                  READY;
    logic [NCH*AWID-1:0]   ADC_OUT;
    logic                  OUT_VALID;
    logic                  OVERRUN;

    deconvolve_multi #(
        .NCH(NCH), .ADC_WIDTH(AWID), .FD_BITS(FDB), .FN_BITS(FNB), .FN_FRAC_BITS(FNF)
    ) dut (
        .CLK(CLK), .RSTN(RSTN), .IN_VALID(IN_VALID), .ADC_IN(ADC_IN), .BYPASS(BYPASS),
        .COEF_LOAD(COEF_LOAD), .FD_IN(FD_IN), .FN_IN(FN_IN), .OVR_CLR(OVR_CLR),
        .READY(READY), .ADC_OUT(ADC_OUT), .OUT_VALID(OUT_VALID), .OVERRUN(OVERRUN)
    );

    always #4 CLK = ~CLK;

    int nvec = 0;
    int nerr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    typedef struct {
        int                  due;
        logic [NCH*AWID-1:0] data;
    } exp_t;

    exp_t                expq[$];
    int                  cyc = 0;
    int                  last_acc = -100;
    bit                  started = 1'b0;
    int                  prev_m [NCH];
    int                  fd_a [NCH];
    int                  fn_a [NCH];
    int                  fd_s [NCH];
    int                  fn_s [NCH];
    bit                  pend_m;
    bit                  ovr_m, rdy_m, ov_m;
    logic [NCH*AWID-1:0] out_m;

    function automatic int model_y(input int x, input int p, input int fd, input int fn, input bit byp);
        int b;
        int y;
        if (byp) return x;
        b = x * 64 - p * fd;
        if (b < 0) b = 0;
        y = (b * fn + 512) / 1024;
        if (y > 4095) y = 4095;
        return y;
    endfunction

    always @(posedge CLK) begin
        bit   acc;
        int   x;
        exp_t e;
        cyc++;
        if (!RSTN) begin
            started = 1'b1;
            expq.delete();
            for (int c = 0; c < NCH; c++) begin
                prev_m[c] = 0; fd_a[c] = 0; fn_a[c] = 16; fd_s[c] = 0; fn_s[c] = 16;
            end
            pend_m = 1'b0; ovr_m = 1'b0; ov_m = 1'b0; rdy_m = 1'b1; out_m = '0;
            last_acc = cyc - 100;
        end else begin
            acc  = IN_VALID && (cyc - last_acc >= NCH);
            ov_m = 1'b0;
            if (expq.size() > 0 && expq[0].due == cyc) begin
                out_m = expq[0].data;
                ov_m  = 1'b1;
                void'(expq.pop_front());
            end
            if (IN_VALID && !acc) ovr_m = 1'b1;
            else if (OVR_CLR) ovr_m = 1'b0;
            if (acc) begin
                if (pend_m) begin
                    fd_a = fd_s; fn_a = fn_s; pend_m = 1'b0;
                end
                e.data = '0;
                for (int c = 0; c < NCH; c++) begin
                    x = int'(ADC_IN[c*AWID +: AWID]);
                    e.data[c*AWID +: AWID] = AWID'(model_y(x, prev_m[c], fd_a[c], fn_a[c], BYPASS));
                    prev_m[c] = x;
                end
                e.due = cyc + LAT;
                expq.push_back(e);
                last_acc = cyc;
            end
            if (COEF_LOAD) begin
                for (int c = 0; c < NCH; c++) begin
                    fd_s[c] = int'(FD_IN[c*FDB +: FDB]);
                    fn_s[c] = int'(FN_IN[c*FNB +: FNB]);
                end
                pend_m = 1'b1;
            end
            rdy_m = (cyc + 1 - last_acc >= NCH);
        end
    end

    always @(negedge CLK) begin
        if (started) begin
            check("out_valid", 64'(OUT_VALID), 64'(ov_m));
            check("ready", 64'(READY), 64'(rdy_m));
            check("overrun", 64'(OVERRUN), 64'(ovr_m));
            check("adc_out", 64'(ADC_OUT), 64'(out_m));
        end
    end

    // ---------------- output capture for literal checks ----------------
    logic [NCH*AWID-1:0] got[$];
    always @(negedge CLK) begin
        if (OUT_VALID) got.push_back(ADC_OUT);
    end

    function automatic int gch(input int k, input int c);
        logic [NCH*AWID-1:0] v;
        if (k >= got.size()) return -1;
        v = got[k];
        return int'(v[c*AWID +: AWID]);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset();
        RSTN = 1'b0;
        tick(2);
        RSTN = 1'b1;
        tick(1);
    endtask

    task automatic set_coef(input int fd0, input int fn0, input int fd1, input int fn1,
                            input int fd2, input int fn2);
        FD_IN = {6'(fd2), 6'(fd1), 6'(fd0)};
        FN_IN = {6'(fn2), 6'(fn1), 6'(fn0)};
    endtask

    task automatic load_coef(input int fd0, input int fn0, input int fd1, input int fn1,
                             input int fd2, input int fn2);
        set_coef(fd0, fn0, fd1, fn1, fd2, fn2);
        COEF_LOAD = 1'b1;
        tick(1);
        COEF_LOAD = 1'b0;
    endtask

    task automatic send(input int x0, input int x1, input int x2, input bit byp, input bit cl);
        ADC_IN    = {12'(x2), 12'(x1), 12'(x0)};
        BYPASS    = byp;
        COEF_LOAD = cl;
        IN_VALID  = 1'b1;
        tick(1);
        IN_VALID  = 1'b0;
        COEF_LOAD = 1'b0;
        BYPASS    = 1'b0;
    endtask

    initial begin
        int lat;
        RSTN = 1'b0; IN_VALID = 1'b0; ADC_IN = '0; BYPASS = 1'b0; COEF_LOAD = 1'b0;
        FD_IN = '0; FN_IN = '0; OVR_CLR = 1'b0;
        tick(3);
        RSTN = 1'b1;
        tick(1);
        check("rst_adc_out", 64'(ADC_OUT), 64'd0);
        check("rst_ready", 64'(READY), 64'd1);
        check("rst_overrun", 64'(OVERRUN), 64'd0);

        // Post-reset identity and latency
        send(1234, 1234, 1234, 1'b0, 1'b0);
        lat = 0;
        while (!OUT_VALID && lat < 20) begin
            tick(1);
            lat++;
        end
        check("identity_latency", 64'(lat), 64'd6);
        check("identity_value", 64'(ADC_OUT), 64'({12'd1234, 12'd1234, 12'd1234}));
        tick(2);

        // Step response, distinct per-channel coefficients
        do_reset();
        load_coef(48, 16, 32, 16, 0, 32);
        got.delete();
        send(100, 200, 1000, 1'b0, 1'b0); tick(2);
        send(100, 200, 1000, 1'b0, 1'b0); tick(2);
        send(100, 200, 1000, 1'b0, 1'b0); tick(8);
        check("step_count", 64'(got.size()), 64'd3);
        check("step_f1_ch0", 64'(gch(0, 0)), 64'd100);
        check("step_f2_ch0", 64'(gch(1, 0)), 64'd25);
        check("step_f3_ch0", 64'(gch(2, 0)), 64'd25);
        check("step_f2_ch1", 64'(gch(1, 1)), 64'd100);
        check("step_f1_ch2", 64'(gch(0, 2)), 64'd2000);

        // Saturation
        do_reset();
        load_coef(0, 63, 0, 63, 0, 63);
        got.delete();
        send(4095, 100, 0, 1'b0, 1'b0); tick(8);
        check("sat_ch0", 64'(gch(0, 0)), 64'd4095);
        check("sat_ch1", 64'(gch(0, 1)), 64'd394);
        check("sat_ch2", 64'(gch(0, 2)), 64'd0);

        // Clamp at zero
        load_coef(48, 16, 63, 1, 10, 40);
        got.delete();
        send(4000, 50, 3000, 1'b0, 1'b0); tick(2);
        send(0, 50, 3000, 1'b0, 1'b0); tick(8);
        check("clamp_pre_ch0", 64'(gch(0, 0)), 64'd929);
        check("clamp_ch0", 64'(gch(1, 0)), 64'd0);

        // Coefficient load on the accept edge
        set_coef(0, 32, 0, 16, 48, 16);
        got.delete();
        send(500, 300, 600, 1'b0, 1'b1); tick(2);
        send(500, 300, 600, 1'b0, 1'b0); tick(8);
        check("coef_old_ch0", 64'(gch(0, 0)), 64'd500);
        check("coef_new_ch0", 64'(gch(1, 0)), 64'd1000);
        check("coef_new_ch1", 64'(gch(1, 1)), 64'd300);
        check("coef_new_ch2", 64'(gch(1, 2)), 64'd150);

        // Overrun: second frame one cycle after the first is dropped
        got.delete();
        ADC_IN = {12'd300, 12'd200, 12'd100};
        IN_VALID = 1'b1;
        tick(1);
        check("ready_busy", 64'(READY), 64'd0);
        ADC_IN = {12'd9, 12'd8, 12'd7};
        tick(1);
        IN_VALID = 1'b0;
        check("ovr_set", 64'(OVERRUN), 64'd1);
        tick(8);
        check("ovr_sticky", 64'(OVERRUN), 64'd1);
        check("ovr_one_output", 64'(got.size()), 64'd1);
        OVR_CLR = 1'b1;
        tick(1);
        OVR_CLR = 1'b0;
        check("ovr_clr", 64'(OVERRUN), 64'd0);
        send(11, 22, 33, 1'b0, 1'b0);
        IN_VALID = 1'b1;
        OVR_CLR  = 1'b1;
        tick(1);
        IN_VALID = 1'b0;
        OVR_CLR  = 1'b0;
        check("ovr_set_priority", 64'(OVERRUN), 64'd1);
        tick(8);
        OVR_CLR = 1'b1;
        tick(1);
        OVR_CLR = 1'b0;

        // Back-to-back frames with a bypass frame in the middle
        got.delete();
        send(1000, 2000, 3000, 1'b0, 1'b0); tick(2);
        send(4000, 10, 20, 1'b1, 1'b0); tick(2);
        send(7, 8, 9, 1'b0, 1'b0); tick(2);
        send(4095, 4095, 4095, 1'b0, 1'b0); tick(9);
        check("b2b_count", 64'(got.size()), 64'd4);
        check("bypass_frame", 64'(gch(1, 0) | (gch(1, 1) << 12) | (gch(1, 2) << 24)),
              64'({12'd20, 12'd10, 12'd4000}));

        // Reset in the middle of a frame
        got.delete();
        send(800, 800, 800, 1'b0, 1'b0);
        tick(1);
        RSTN = 1'b0;
        tick(1);
        RSTN = 1'b1;
        tick(10);
        check("midrst_no_output", 64'(got.size()), 64'd0);
        load_coef(48, 16, 48, 16, 48, 16);
        send(100, 100, 100, 1'b0, 1'b0); tick(8);
        check("midrst_prev_cleared", 64'(gch(0, 0)), 64'd100);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got time %0t expected below 200000", $time);
        $fatal(1);
    end
endmodule

// File: doc/deconvolve_multi.md
# deconvolve_multi

Parametrised multi-channel FADC trace deconvolution. One multiplier pipeline is time-multiplexed across NCH channels at 120 MHz. Each channel gets y[n] = FN·(x[n] − FD·x[n−1]), with a clamp at zero, rounding and saturation. Per-channel coefficients are runtime-loadable and take effect atomically at a frame boundary. The block sits between the filtered ADC path and the compatibility ToTd trigger logic, and supersedes the single-channel fixed 40 MHz deconvolver.

## Interface
- NCH, 3: channel count (1..8).
- ADC_WIDTH, 12: sample width.
- FD_BITS, 6: decay constant, all fractional (.yyyyyy).
- FN_BITS, 6: normaliser width.
- FN_FRAC_BITS, 4: normaliser fractional bits (xx.yyyy).

- CLK  in  1  120 MHz clock.
- RSTN  in  1  synchronous reset, active low.
- IN_VALID  in  1  frame strobe; ADC_IN is sampled on this edge.
- ADC_IN  in  NCH·ADC_WIDTH  channel c at bits [c·ADC_WIDTH +: ADC_WIDTH].
- BYPASS  in  1  sampled with the frame; output = input, same latency.
- COEF_LOAD  in  1  pulse; samples FD_IN/FN_IN into the shadow set.
- FD_IN  in  NCH·FD_BITS  per-channel decay constants.
- FN_IN  in  NCH·FN_BITS  per-channel normalisers.
- OVR_CLR  in  1  clears OVERRUN.
- READY  out  1  registered; high when IN_VALID on the next edge will be accepted.
- ADC_OUT  out  NCH·ADC_WIDTH  deconvolved frame, updated atomically.
- OUT_VALID  out  1  one-cycle pulse with each ADC_OUT update.
- OVERRUN  out  1  sticky; a frame was dropped.

## Operation
- Sequencer states:
  - IDLE: on accepted IN_VALID, latch ADC_IN and BYPASS into the frame register, go to ISSUE with k=0.
  - ISSUE: issue channel k into the pipeline each cycle. After k=NCH−1, go to IDLE, or stay in ISSUE with k=0 if a new IN_VALID is accepted on that edge.
- Acceptance: IN_VALID is accepted in IDLE, or on the edge the last channel is issued. READY reflects exactly this condition.
  - IN_VALID at any other time: frame dropped, OVERRUN set, pipeline undisturbed.
- Per-channel history: PREV[c] holds the last accepted sample of channel c. It is read and then overwritten with x when channel c enters S1.
- Arithmetic per channel (x = new sample, p = PREV[c]):
  - S1: A = p·FD (ADC_WIDTH+FD_BITS bits); X = x<<FD_BITS.
  - S2: B = X − A, signed, ADC_WIDTH+FD_BITS+1 bits. If B < 0 then C = 0, else C = B.
  - S3: D = C·FN (ADC_WIDTH+FD_BITS+FN_BITS bits).
  - S4: E = D + 2^(FD_BITS+FN_FRAC_BITS−1); y = E >> (FD_BITS+FN_FRAC_BITS).
  - If y > 2^ADC_WIDTH−1, y = 2^ADC_WIDTH−1.
  - BYPASS frames: y = x. PREV is still updated.
- Output assembly:
  - Channels 0..NCH−2 write a staging register.
  - The last channel's S4 loads ADC_OUT = {y_last, staging} and pulses OUT_VALID.
  - Back-to-back frames never corrupt an output frame.
- Coefficients:
  - COEF_LOAD copies FD_IN/FN_IN into the shadow set and sets PENDING.
  - On an accepted IN_VALID with PENDING already set, active ← shadow, PENDING cleared, and that frame uses the new set.
  - COEF_LOAD on the same edge as an accepted IN_VALID: that frame uses the old active set; the new set applies to the next frame.
  - The active set is held per frame; no mid-frame coefficient change.
- OVERRUN: set has priority over OVR_CLR when both occur on the same edge.

## Timing
- Accepted IN_VALID at edge E0. Channel k registers S1..S4 at edges E(1+k)..E(4+k).
- ADC_OUT and OUT_VALID update at edge E(NCH+3). NCH=3 gives 6 cycles.
- Minimum IN_VALID spacing is NCH cycles; sustained 40 MHz input with NCH=3 is lossless.
- Reset (RSTN low at an edge):
  - ADC_OUT=0, OUT_VALID=0, OVERRUN=0, READY=1 from the following cycle.
  - PREV=0, pipeline and staging flushed, sequencer IDLE, PENDING=0.
  - Active and shadow FD=0, FN=2^FN_FRAC_BITS (unity), so the post-reset transfer is identity.
- Reset mid-frame: the in-flight frame is discarded and no OUT_VALID is produced for it.

## Test plan
- Post-reset identity: x=1234 on all channels → ADC_OUT=1234 each, OUT_VALID exactly at E6.
- Step response, FD=48 (0.75), FN=16 (1.0), ch0 steady at x=100, frames 3 cycles apart:
  - Frame 1 → y=100.
  - Frames 2 and later → y=25.
- Saturation: FN=63, FD=0, x=4095, PREV=0 → y=4095.
- Clamp: FD=48, PREV=4000 then x=0 → y=0 (not wrapped).
- Coefficient timing:
  - COEF_LOAD on the same edge as IN_VALID → that frame uses old coefficients; the next frame uses new ones.
  - Per-channel values differ with no channel crosstalk.
- Overrun and reset:
  - IN_VALID at E0 and E1 → second frame dropped, OVERRUN=1 until OVR_CLR, READY low during ISSUE.
  - Back-to-back frames at a 3-cycle spacing → all outputs correct.
  - RSTN low at E2 → no OUT_VALID, PREV=0 afterwards.
